// File: rtl/reconciled_key_bank_ctrl_pkg.sv
// Shared definitions for the reconciled-key bank controller.
// Holds the FSM state encoding (also exposed on state_o for debug/ILA)
// and the geometry of the reconciled-key BRAM: two banks of 16384 keys
// each, selected by the ER engine's sifted_key_addr_index.
package qkd_key_bank_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_ABORT  = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    RUN    = ST_RUN,
    COMMIT = ST_COMMIT,
    ABORT  = ST_ABORT
  } state_t;

  localparam int NUM_BANKS  = 2;
  localparam int BANK_DEPTH = 16384;
  localparam int KEY_ADDR_W = 15;

endpackage

// File: rtl/reconciled_key_bank_ctrl_if.sv
// Handshake bundle between the bank controller, the ER engine and the
// key consumer.
//   ER side      : er_wait, er_finish, er_fail (to controller),
//                  er_start, er_addr_index (from controller)
//   Consumer side: key_release (to controller),
//                  key_valid, key_bank (from controller)
// master = the controller, slave = the ER engine / consumer side.
interface reconciled_key_bank_ctrl_if;

  logic er_wait;
  logic er_finish;
  logic er_fail;
  logic er_start;
  logic er_addr_index;
  logic key_valid;
  logic key_bank;
  logic key_release;

  modport master (
    input  er_wait, er_finish, er_fail, key_release,
    output er_start, er_addr_index, key_valid, key_bank
  );

  modport slave (
    output er_wait, er_finish, er_fail, key_release,
    input  er_start, er_addr_index, key_valid, key_bank
  );

endinterface

// File: rtl/reconciled_key_bank_ctrl.sv
// Frame scheduler for Bob's error-reconciliation engine and the two-bank
// reconciled-key BRAM. Each frame picks the write bank, strobes ER start,
// waits for finish/fail/timeout and then commits or discards the bank.
// Committed banks are handed to the consumer as a 2-deep in-order FIFO.
// Ports:
//   clk, rst_n      : 100 MHz ER clock, synchronous active-low reset
//   start_switch    : level enable for scheduling new frames
//   bus (master)    : ER handshake and consumer key_valid/key_bank/release
//   bank_full       : per-bank committed flags
//   busy            : FSM not in IDLE
//   timeout_flag    : sticky RUN-timeout indication
//   frame_ok_cnt    : committed frames (saturating)
//   frame_fail_cnt  : discarded frames (saturating)
//   state_o         : FSM state for debug
module reconciled_key_bank_ctrl
  import qkd_key_bank_pkg::*;
#(
  parameter int unsigned START_PULSE_LEN = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 100_000_000,
  parameter int          CNT_W           = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_switch,
  reconciled_key_bank_ctrl_if.master  bus,
  output logic [NUM_BANKS-1:0]        bank_full,
  output logic                        busy,
  output logic                        timeout_flag,
  output logic [CNT_W-1:0]            frame_ok_cnt,
  output logic [CNT_W-1:0]            frame_fail_cnt,
  output logic [2:0]                  state_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                state;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  fail_latch;
  logic                  er_start_q;
  logic                  addr_q;
  logic [15:0]           pulse_cnt;
  logic [31:0]           tmo_cnt;
  logic                  release_ok;
  logic                  pulse_done;
  logic                  tmo_hit;
  logic [NUM_BANKS-1:0]  bank_set;
  logic [NUM_BANKS-1:0]  bank_clr;

  // The writer only ever targets a non-full bank and the reader only a full
  // one, so a same-cycle set and clear always hit different banks.
  always_comb begin
    release_ok = bus.key_release & bank_full[rd_ptr];
    pulse_done = (pulse_cnt == 16'(START_PULSE_LEN - 1));
    tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TIMEOUT_CYCLES - 1);
    bank_set   = '0;
    bank_clr   = '0;
    if (state == COMMIT && !fail_latch) bank_set[wr_ptr] = 1'b1;
    if (release_ok)                     bank_clr[rd_ptr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      bank_full      <= '0;
      fail_latch     <= 1'b0;
      er_start_q     <= 1'b0;
      addr_q         <= 1'b0;
      pulse_cnt      <= '0;
      tmo_cnt        <= '0;
      timeout_flag   <= 1'b0;
      frame_ok_cnt   <= '0;
      frame_fail_cnt <= '0;
    end else begin
      bank_full <= (bank_full | bank_set) & ~bank_clr;
      if (release_ok) rd_ptr <= ~rd_ptr;

      case (state)
        IDLE: begin
          // A full target bank holds the scheduler here (backpressure).
          if (start_switch && bus.er_wait && !bank_full[wr_ptr]) begin
            state      <= START;
            er_start_q <= 1'b1;
            addr_q     <= wr_ptr;
            pulse_cnt  <= '0;
            fail_latch <= 1'b0;
          end
        end
        START: begin
          fail_latch <= fail_latch | bus.er_fail;
          if (pulse_done) begin
            state      <= RUN;
            er_start_q <= 1'b0;
            tmo_cnt    <= '0;
          end else begin
            pulse_cnt <= pulse_cnt + 16'd1;
          end
        end
        RUN: begin
          // Fail sampled alongside finish still counts; finish beats timeout.
          fail_latch <= fail_latch | bus.er_fail;
          if (bus.er_finish)  state   <= COMMIT;
          else if (tmo_hit)   state   <= ABORT;
          else                tmo_cnt <= tmo_cnt + 32'd1;
        end
        COMMIT: begin
          if (!fail_latch) begin
            wr_ptr       <= ~wr_ptr;
            frame_ok_cnt <= sat_inc(frame_ok_cnt);
          end else begin
            frame_fail_cnt <= sat_inc(frame_fail_cnt);
          end
          state <= IDLE;
        end
        ABORT: begin
          timeout_flag   <= 1'b1;
          frame_fail_cnt <= sat_inc(frame_fail_cnt);
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.er_start      = er_start_q;
  assign bus.er_addr_index = addr_q;
  assign bus.key_valid     = bank_full[rd_ptr];
  assign bus.key_bank      = rd_ptr;
  assign busy              = (state != IDLE);
  assign state_o           = state;

endmodule

// File: tb/tb_reconciled_key_bank_ctrl.sv
// Self-checking bench for reconciled_key_bank_ctrl: a table of frame
// records with hand-computed bank/pointer/counter results, followed by
// hand-written sequences for backpressure, timeout and mid-frame reset.
module tb_reconciled_key_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_switch;
  logic [1:0]  bank_full;
  logic        busy;
  logic        timeout_flag;
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_fail_cnt;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reconciled_key_bank_ctrl_if bus ();

  reconciled_key_bank_ctrl #(
    .START_PULSE_LEN (4),
    .TIMEOUT_CYCLES  (100),
    .CNT_W           (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_switch   (start_switch),
    .bus            (bus),
    .bank_full      (bank_full),
    .busy           (busy),
    .timeout_flag   (timeout_flag),
    .frame_ok_cnt   (frame_ok_cnt),
    .frame_fail_cnt (frame_fail_cnt),
    .state_o        (state_o)
  );

  typedef struct {
    logic       rel_before;
    logic       fail;
    int         delay;
    logic       rel_commit;
    logic       exp_addr;
    logic [1:0] exp_bf;
    logic       exp_kv;
    logic       exp_kb;
    int         exp_ok;
    int         exp_fail;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_release();
    bus.key_release = 1'b1;
    tick();
    bus.key_release = 1'b0;
  endtask

  // Entered one sample after the IDLE->START edge.
  task automatic finish_frame(input logic fail, input int delay, input logic rel_commit,
                              output logic addr);
    int pulses = 0;
    int n = 0;
    addr = bus.er_addr_index;
    while (state_o != 3'd2 && n < 20) begin
      if (bus.er_start) pulses++;
      tick();
      n++;
    end
    chk("er_start_len", pulses, 4);
    chk("run_entry", state_o, 3'd2);
    for (int i = 0; i < delay; i++) begin
      bus.er_fail = fail && (i == delay / 2);
      tick();
    end
    bus.er_fail   = 1'b0;
    bus.er_finish = 1'b1;
    tick();
    bus.er_finish = 1'b0;
    chk("commit_state", state_o, 3'd3);
    if (rel_commit) bus.key_release = 1'b1;
    tick();
    bus.key_release = 1'b0;
    chk("idle_after", state_o, 3'd0);
  endtask

  task automatic run_frame(input logic fail, input int delay, input logic rel_commit,
                           output logic addr);
    bus.er_wait = 1'b1;
    tick();
    bus.er_wait = 1'b0;
    finish_frame(fail, delay, rel_commit, addr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic addr;
    int   seen;
    int   n;
    int   runs;

    rst_n           = 1'b0;
    start_switch    = 1'b0;
    bus.er_wait     = 1'b0;
    bus.er_finish   = 1'b0;
    bus.er_fail     = 1'b0;
    bus.key_release = 1'b0;
    repeat (3) tick();

    chk("rst_er_start", bus.er_start, 0);
    chk("rst_addr", bus.er_addr_index, 0);
    chk("rst_key_valid", bus.key_valid, 0);
    chk("rst_key_bank", bus.key_bank, 0);
    chk("rst_bank_full", bank_full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_flag, 0);
    chk("rst_ok_cnt", frame_ok_cnt, 0);
    chk("rst_fail_cnt", frame_fail_cnt, 0);
    chk("rst_state", state_o, 0);

    rst_n = 1'b1;
    tick();

    //          rel_b fail  dly rel_c addr  bf     kv    kb    ok fail
    vecs[0] = '{1'b0, 1'b0, 50, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1, 0};
    vecs[1] = '{1'b0, 1'b1, 20, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1, 1};
    vecs[2] = '{1'b0, 1'b0, 10, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 2, 1};
    vecs[3] = '{1'b1, 1'b0, 15, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 3, 1};
    vecs[4] = '{1'b0, 1'b0,  5, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 4, 1};

    start_switch = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (vecs[k].rel_before) pulse_release();
      run_frame(vecs[k].fail, vecs[k].delay, vecs[k].rel_commit, addr);
      chk($sformatf("v%0d_addr", k), addr, vecs[k].exp_addr);
      chk($sformatf("v%0d_bank_full", k), bank_full, vecs[k].exp_bf);
      chk($sformatf("v%0d_key_valid", k), bus.key_valid, vecs[k].exp_kv);
      chk($sformatf("v%0d_key_bank", k), bus.key_bank, vecs[k].exp_kb);
      chk($sformatf("v%0d_ok_cnt", k), frame_ok_cnt, vecs[k].exp_ok);
      chk($sformatf("v%0d_fail_cnt", k), frame_fail_cnt, vecs[k].exp_fail);
    end

    // Both banks full: requests are withheld until bank 0 is released.
    bus.er_wait = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.er_start || busy) seen++;
    end
    chk("bp_no_start", seen, 0);
    chk("bp_state", state_o, 0);
    bus.key_release = 1'b1;
    tick();
    bus.key_release = 1'b0;
    chk("bp_rel_bank_full", bank_full, 2'b10);
    chk("bp_rel_key_bank", bus.key_bank, 1);
    tick();
    chk("bp_restart", bus.er_start, 1);
    chk("bp_restart_addr", bus.er_addr_index, 0);
    bus.er_wait = 1'b0;
    finish_frame(1'b0, 30, 1'b0, addr);
    chk("bp_bank_full", bank_full, 2'b11);
    chk("bp_ok_cnt", frame_ok_cnt, 5);
    chk("bp_key_bank", bus.key_bank, 1);

    // Timeout: free bank 1, start a frame and never finish it.
    pulse_release();
    chk("to_pre_bank_full", bank_full, 2'b01);
    bus.er_wait = 1'b1;
    tick();
    bus.er_wait = 1'b0;
    n = 0;
    while (state_o != 3'd2 && n < 20) begin
      tick();
      n++;
    end
    chk("to_run_entry", state_o, 3'd2);
    runs = 0;
    while (state_o == 3'd2 && runs < 300) begin
      runs++;
      tick();
    end
    chk("to_run_cycles", runs, 100);
    chk("to_abort_state", state_o, 3'd4);
    tick();
    chk("to_idle", state_o, 0);
    chk("to_flag", timeout_flag, 1);
    chk("to_fail_cnt", frame_fail_cnt, 2);
    chk("to_busy", busy, 0);
    chk("to_bank_full", bank_full, 2'b01);
    run_frame(1'b0, 5, 1'b0, addr);
    chk("to_reuse_addr", addr, 1);
    chk("to_flag_sticky", timeout_flag, 1);
    chk("to_next_bank_full", bank_full, 2'b11);
    chk("to_next_ok_cnt", frame_ok_cnt, 6);

    // Reset in the middle of RUN.
    pulse_release();
    bus.er_wait = 1'b1;
    tick();
    bus.er_wait = 1'b0;
    n = 0;
    while (state_o != 3'd2 && n < 20) begin
      tick();
      n++;
    end
    chk("mr_run_entry", state_o, 3'd2);
    repeat (10) tick();
    start_switch = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_er_start", bus.er_start, 0);
    chk("mr_addr", bus.er_addr_index, 0);
    chk("mr_key_valid", bus.key_valid, 0);
    chk("mr_key_bank", bus.key_bank, 0);
    chk("mr_bank_full", bank_full, 0);
    chk("mr_busy", busy, 0);
    chk("mr_timeout", timeout_flag, 0);
    chk("mr_ok_cnt", frame_ok_cnt, 0);
    chk("mr_fail_cnt", frame_fail_cnt, 0);
    chk("mr_state", state_o, 0);
    bus.er_finish = 1'b1;
    tick();
    bus.er_finish = 1'b0;
    tick();
    chk("spur_state", state_o, 0);
    chk("spur_ok_cnt", frame_ok_cnt, 0);
    chk("spur_fail_cnt", frame_fail_cnt, 0);
    chk("spur_bank_full", bank_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
